// File: rtl/mux_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_types_pkg
//  Description : Shared select/state enumerations for the datapath muxes and
//                the elastic pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_types_pkg;

    // Operand-select encodings used by the datapath muxes.
    typedef enum logic [1:0] {
        SEL_REG  = 2'd0,
        SEL_IMM  = 2'd1,
        SEL_PC   = 2'd2,
        SEL_ZERO = 2'd3
    } mux_sel_t;

    // Forwarding-select encodings used by the hazard logic.
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_WB   = 2'd3
    } fwd_sel_t;

    // Fill level of a two-entry pipeline stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int c_OCC_W = 2;

    // Number of entries held in a given stage state.
    function automatic logic [c_OCC_W-1:0] occ_of(input pipe_state_t st);
        case (st)
            ONE:     occ_of = 2'd1;
            TWO:     occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage : mux_types_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; clr wins over inc.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            inc,
    input  logic            clr,
    output logic [CNTW-1:0] count
);

    localparam logic [CNTW-1:0] c_MAX = '1;
    localparam logic [CNTW-1:0] c_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [CNTW-1:0] r_count;

    // Count qualifying cycles, stopping at the maximum instead of wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage
//  Description : Two-entry valid/ready pipeline stage (main + skid register)
//                with registered handshake outputs, flush and a saturating
//                back-pressure counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage
    import mux_types_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNTW   = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNTW-1:0]  stall_cnt,
    input  logic             stall_clr
);

    pipe_state_t      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    pipe_state_t      w_state_nxt;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_accept;
    logic             w_consume;
    logic             w_stall;

    // Handshake outputs decode state only, so no ready/valid path crosses the stage.
    assign in_ready  = (r_state != TWO);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign occupancy = occ_of(r_state);

    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;
    assign w_stall   = out_valid & ~out_ready;

    // Next-state and storage update; flush overrides every handshake event.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = BUBBLE;
            w_skid_nxt  = BUBBLE;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_nxt  = in_data;
                    end else if (w_accept) begin
                        w_state_nxt = TWO;
                        w_skid_nxt  = in_data;
                    end else if (w_consume) begin
                        w_state_nxt = EMPTY;
                        w_main_nxt  = BUBBLE;
                    end
                end
                TWO: begin
                    // Skid entry is older than anything upstream, so it moves to the head.
                    if (w_consume) begin
                        w_state_nxt = ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = BUBBLE;
                    w_skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

    // State and payload registers, cleared to the bubble value on reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    sat_counter #(
        .CNTW (CNTW)
    ) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (w_stall),
        .clr   (stall_clr),
        .count (stall_cnt)
    );

endmodule : pipe_stage
`default_nettype wire

// File: tb/tb_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage
//  Description : Self-checking bench for pipe_stage against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage;

    localparam logic [31:0] BUB  = 32'hDEAD_BEEF;
    localparam logic [7:0]  BUB8 = 8'h5A;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, stall_clr = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0, s_stall_clr = 1'b0;
    logic [7:0]  s_in_data = '0;
    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_out_data;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO contents (max 2) and the stall count.
    logic [31:0] q[$];
    int          m_cnt = 0;

    always #5 CLK = ~CLK;

    pipe_stage #(.WIDTH(32), .BUBBLE(BUB), .CNTW(16)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    pipe_stage #(.WIDTH(8), .BUBBLE(BUB8), .CNTW(4)) dut_sat (
        .CLK(CLK), .nRST(nRST), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .stall_clr(s_stall_clr)
    );

    function automatic logic [31:0] exp_data();
        return (q.size() > 0) ? q[0] : BUB;
    endfunction

    task automatic drive(input logic fl, input logic iv, input logic [31:0] d,
                         input logic ordy, input logic sclr);
        @(negedge CLK);
        flush = fl; in_valid = iv; in_data = d; out_ready = ordy; stall_clr = sclr;
    endtask

    // Advance the model by the edge that is about to happen.
    task automatic model_tick();
        bit mv, acc, con;
        mv  = (q.size() > 0);
        acc = in_valid && (q.size() < 2);
        con = mv && out_ready;
        if (stall_clr) m_cnt = 0;
        else if (mv && !out_ready && m_cnt < 65535) m_cnt++;
        if (flush) q.delete();
        else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(in_data);
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        flush = 0; in_valid = 0; in_data = '0; out_ready = 0; stall_clr = 0;
        s_flush = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 0; s_stall_clr = 0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        q.delete();
        m_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLK);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== BUB ||
            occupancy !== 2'd0 || stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset: got rdy=%b vld=%b data=%h occ=%0d cnt=%0d, expected 1 0 %h 0 0",
                     in_ready, out_valid, out_data, occupancy, stall_cnt, BUB);
        end
    endtask

    task automatic test_passthrough();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, (k <= 8), 32'(k), 1'b1, 1'b0);
            n_vec++;
            if (k >= 2 && k <= 9) begin
                if (out_valid !== 1'b1 || out_data !== 32'(k - 1)) begin
                    n_err++;
                    $display("FAIL passthrough[%0d]: got vld=%b data=%h, expected 1 %h",
                             k, out_valid, out_data, 32'(k - 1));
                end
            end else if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL passthrough_idle[%0d]: got vld=%b, expected 0", k, out_valid);
            end
            n_vec++;
            if (occupancy > 2'd1) begin
                n_err++;
                $display("FAIL passthrough_occ[%0d]: got %0d, expected <=1", k, occupancy);
            end
            model_tick();
        end
    endtask

    task automatic test_skid();
        do_reset();
        drive(1'b0, 1'b1, 32'hA, 1'b0, 1'b0); model_tick();
        drive(1'b0, 1'b1, 32'hB, 1'b0, 1'b0); model_tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || stall_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL skid_full: got occ=%0d rdy=%b cnt=%0d, expected 2 0 1",
                     occupancy, in_ready, stall_cnt);
        end
        model_tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (stall_cnt !== 16'd2 || out_data !== 32'hA) begin
            n_err++;
            $display("FAIL skid_head: got cnt=%0d data=%h, expected 2 0000000a", stall_cnt, out_data);
        end
        model_tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || occupancy !== 2'd1) begin
            n_err++;
            $display("FAIL skid_second: got vld=%b data=%h occ=%0d, expected 1 0000000b 1",
                     out_valid, out_data, occupancy);
        end
        model_tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== BUB) begin
            n_err++;
            $display("FAIL skid_drain: got vld=%b data=%h, expected 0 %h", out_valid, out_data, BUB);
        end
        model_tick();
    endtask

    task automatic test_flush_collision();
        do_reset();
        drive(1'b0, 1'b1, 32'h1, 1'b0, 1'b0); model_tick();
        drive(1'b0, 1'b1, 32'h2, 1'b0, 1'b0); model_tick();
        drive(1'b1, 1'b1, 32'hC, 1'b0, 1'b0); model_tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== BUB || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush: got occ=%0d vld=%b data=%h rdy=%b, expected 0 0 %h 1",
                     occupancy, out_valid, out_data, in_ready, BUB);
        end
        model_tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            n_vec++;
            if (out_valid !== 1'b0 || out_data === 32'hC) begin
                n_err++;
                $display("FAIL flush_leak[%0d]: got vld=%b data=%h, expected 0 %h",
                         k, out_valid, out_data, BUB);
            end
            model_tick();
        end
        // Flush with a live consume still empties the stage.
        drive(1'b0, 1'b1, 32'h7, 1'b1, 1'b0); model_tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h7) begin
            n_err++;
            $display("FAIL flush_consume: got vld=%b data=%h, expected 1 00000007", out_valid, out_data);
        end
        model_tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_err++;
            $display("FAIL flush_consume_after: got vld=%b occ=%0d, expected 0 0", out_valid, occupancy);
        end
        model_tick();
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge CLK);
        s_in_valid = 1'b1; s_in_data = 8'h33; s_out_ready = 1'b0;
        @(negedge CLK);
        s_in_valid = 1'b0;
        repeat (20) @(negedge CLK);
        n_vec++;
        if (s_stall_cnt !== 4'd15 || s_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL saturate: got cnt=%0d vld=%b, expected 15 1", s_stall_cnt, s_out_valid);
        end
        s_stall_clr = 1'b1;
        @(negedge CLK);
        s_stall_clr = 1'b0;
        n_vec++;
        if (s_stall_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL sat_clear: got cnt=%0d, expected 0", s_stall_cnt);
        end
        @(negedge CLK);
        n_vec++;
        if (s_stall_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL sat_resume: got cnt=%0d, expected 1", s_stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b0, 1'b1, 32'h11, 1'b0, 1'b0); model_tick();
        drive(1'b0, 1'b1, 32'h22, 1'b0, 1'b0); model_tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2 nRST = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== BUB ||
            occupancy !== 2'd0 || stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: got rdy=%b vld=%b data=%h occ=%0d cnt=%0d, expected 1 0 %h 0 0",
                     in_ready, out_valid, out_data, occupancy, stall_cnt, BUB);
        end
        q.delete();
        m_cnt = 0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b0, 1'b1, 32'h99, 1'b0, 1'b0); model_tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++;
        if (occupancy !== 2'd1 || out_data !== 32'h99) begin
            n_err++;
            $display("FAIL async_release: got occ=%0d data=%h, expected 1 00000099", occupancy, out_data);
        end
        model_tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), $urandom,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
            n_vec++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
                out_data !== exp_data() || occupancy !== 2'(q.size()) || stall_cnt !== 16'(m_cnt)) begin
                n_err++;
                $display("FAIL random[%0d]: got vld=%b rdy=%b data=%h occ=%0d cnt=%0d, expected %b %b %h %0d %0d",
                         i, out_valid, in_ready, out_data, occupancy, stall_cnt,
                         (q.size() > 0), (q.size() < 2), exp_data(), q.size(), m_cnt);
            end
            model_tick();
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_skid();
        test_flush_collision();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_stage
`default_nettype wire
